// File: rtl/df_sign_fir.sv
// -----------------------------------------------------------------------------
// df_opt_2comp
//   Optional two's-complement stage. It passes an unsigned 8-bit sample
//   through as a 9-bit signed value, or negates it when en is high.
//   Result range is -255..+255.
//   a  : unsigned 8-bit sample
//   en : 1 = negate
//   y  : 9-bit signed result
//
// df_sign_fir
//   Sequential FIR stage with coefficients restricted to +/-2^s or zero.
//   One sample is accepted in IDLE. ACCUM then walks the delay line one tap
//   per cycle through a single shared df_opt_2comp instance. The registered
//   sum is offered on a ready/valid output in OUTPUT.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_data/in_valid    : unsigned sample input
//   in_ready            : high only in IDLE
//   coef_en/coef_neg    : per-tap enable and sign (1 = negative)
//   coef_shift          : per-tap left shift 0..3, tap k at [2k+1:2k]
//   out_data/out_valid  : signed filter result
//   out_ready           : consumer takes the result
// -----------------------------------------------------------------------------
module df_opt_2comp (
  input  logic [7:0] a,
  input  logic       en,
  output logic [8:0] y
);
  assign y = en ? -{1'b0, a} : {1'b0, a};
endmodule

module df_sign_fir #(
  parameter int NTAPS = 4,
  parameter int ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NTAPS-1:0]     coef_en,
  input  logic [NTAPS-1:0]     coef_neg,
  input  logic [2*NTAPS-1:0]   coef_shift,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int IDX_W = $clog2(NTAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t state, state_nxt;

  logic [7:0]         taps [NTAPS];
  logic [NTAPS-1:0]   snap_en;
  logic [NTAPS-1:0]   snap_neg;
  logic [2*NTAPS-1:0] snap_shift;
  logic [IDX_W-1:0]   tap_idx;
  logic [ACC_W-1:0]   acc;

  logic               accept;
  logic               last_tap;
  logic [7:0]         cur_sample;
  logic               cur_en;
  logic               cur_neg;
  logic [1:0]         cur_shift;
  logic [8:0]         comp_out;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   acc_sum;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign last_tap = (state == S_ACCUM) && (tap_idx == LAST_IDX);

  // Select the delay-line value and coefficient snapshot of the current tap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and infers a latch.
    cur_sample = '0;
    cur_en     = 1'b0;
    cur_neg    = 1'b0;
    cur_shift  = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (IDX_W'(k) == tap_idx) begin
        cur_sample = taps[k];
        cur_en     = snap_en[k];
        cur_neg    = snap_neg[k];
        cur_shift  = snap_shift[2*k +: 2];
      end
    end
  end

  df_opt_2comp u_2comp (
    .a  (cur_sample),
    .en (cur_neg),
    .y  (comp_out)
  );

  // Sign-extend the 9-bit term, then apply the power-of-two weight.
  always_comb begin
    term = '0;
    if (cur_en) begin
      term = {{(ACC_W-9){comp_out[8]}}, comp_out} << cur_shift;
    end
  end

  assign acc_sum = acc + term;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid)  state_nxt = S_ACCUM;
      S_ACCUM:  if (last_tap)  state_nxt = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay line is reset explicitly because unfilled taps must
      // contribute zero; this keeps it as flops rather than a RAM.
      for (int k = 0; k < NTAPS; k++) begin
        taps[k] <= '0;
      end
      snap_en    <= '0;
      snap_neg   <= '0;
      snap_shift <= '0;
      tap_idx    <= '0;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        taps[0] <= in_data;
        for (int k = 1; k < NTAPS; k++) begin
          taps[k] <= taps[k-1];
        end
        // The coefficients are frozen here so later input changes cannot
        // disturb a result in progress.
        snap_en    <= coef_en;
        snap_neg   <= coef_neg;
        snap_shift <= coef_shift;
        acc        <= '0;
        tap_idx    <= '0;
      end

      if (state == S_ACCUM) begin
        acc     <= acc_sum;
        tap_idx <= tap_idx + IDX_W'(1);
        if (last_tap) begin
          out_data  <= acc_sum;
          out_valid <= 1'b1;
        end
      end

      if (state == S_OUTPUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_df_sign_fir.sv
// -----------------------------------------------------------------------------
// tb_df_sign_fir
//   Scoreboard bench for df_sign_fir (NTAPS=4, ACC_W=16). A reference model
//   of the delay line computes each expected result at the moment a sample is
//   accepted. A negedge monitor pops and compares results on every output
//   handshake and checks accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_df_sign_fir;
  localparam int NTAPS = 4;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       coef_en = '0;
  logic [3:0]       coef_neg = '0;
  logic [7:0]       coef_shift = '0;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;

  df_sign_fir #(.NTAPS(NTAPS), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_en    (coef_en),
    .coef_neg   (coef_neg),
    .coef_shift (coef_shift),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [ACC_W-1:0] exp_q [$];
  int               acc_q [$];
  int               last_acc = 0;
  int               prev_acc = 0;
  logic             prev_valid = 1'b0;
  int               dl [NTAPS];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accepts, latency and result scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        prev_acc = last_acc;
        last_acc = cyc + 1;
      end
      if (out_valid && !prev_valid) begin
        n_tests++;
        if (acc_q.size() == 0) begin
          n_fail++;
          $display("FAIL latency: out_valid rose with no accepted sample at cycle %0d", cyc);
        end else begin
          int a;
          a = acc_q.pop_front();
          if (cyc - a !== NTAPS) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d", cyc - a, NTAPS);
          end
        end
      end
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %0d, no result expected", $signed(out_data));
        end else begin
          logic [ACC_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL out_data: got %0d (0x%h), expected %0d (0x%h)",
                     $signed(out_data), out_data, $signed(e), e);
          end
        end
      end
    end
  end

  // Reference model: shift the line and compute the weighted sum from the
  // coefficient inputs present at the accept edge.
  task automatic model_accept(input logic [7:0] x);
    int sum;
    for (int k = NTAPS - 1; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = x;
    sum = 0;
    for (int k = 0; k < NTAPS; k++) begin
      int w;
      w = coef_en[k] ? (1 << coef_shift[2*k +: 2]) : 0;
      if (coef_neg[k]) w = -w;
      sum += w * dl[k];
    end
    exp_q.push_back(ACC_W'(sum));
  endtask

  task automatic send(input logic [7:0] x, input logic [3:0] en,
                      input logic [3:0] neg, input logic [7:0] sh);
    int waited;
    waited = 0;
    coef_en = en; coef_neg = neg; coef_shift = sh;
    in_data = x; in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(x);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NTAPS; k++) dl[k] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h, required 1 0 0000",
               in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] xs [4];
    xs[0] = 8'd10; xs[1] = 8'd20; xs[2] = 8'd30; xs[3] = 8'd40;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], 4'hF, 4'h0, 8'h00);
      if (i > 0) begin
        n_tests++;
        if (last_acc - prev_acc !== NTAPS + 2) begin
          n_fail++;
          $display("FAIL sample_period: got %0d cycles, expected %0d",
                   last_acc - prev_acc, NTAPS + 2);
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_mixed_sign();
    do_reset();
    send(8'd200, 4'b0011, 4'b0010, 8'h00);
    send(8'd50,  4'b0011, 4'b0010, 8'h00);
    wait_drain();
  endtask

  task automatic test_neg_shift();
    do_reset();
    for (int i = 0; i < 4; i++) send(8'd255, 4'hF, 4'hF, 8'hFF);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    out_ready = 1'b0;
    send(8'd60, 4'hF, 4'h0, 8'h00);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_data = 8'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'd60 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: out_valid=%b out_data=%0d in_ready=%b, required 1 60 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    model_accept(8'd99);
    #1;
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_99: in_ready=%b, required 0 after accept", in_ready);
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'd100, 4'hF, 4'h0, 8'h00);
    wait_drain();
    send(8'd100, 4'hF, 4'h0, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NTAPS; k++) dl[k] = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b out_data=%h, required 0 1 0000",
               out_valid, in_ready, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < NTAPS + 2; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      if (seen != 0) begin
        n_fail++;
        $display("FAIL discarded_result: out_valid high %0d cycles, required 0", seen);
      end
    end
    send(8'd7, 4'hF, 4'h0, 8'h00);
    wait_drain();
  endtask

  task automatic test_snapshot();
    do_reset();
    send(8'd40, 4'hF, 4'h0, 8'h00);
    coef_neg = 4'hF;
    coef_shift = 8'hFF;
    wait_drain();
    coef_neg = 4'h0;
    coef_shift = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NTAPS; k++) dl[k] = 0;
    test_reset();
    test_basic();
    test_mixed_sign();
    test_neg_shift();
    test_backpressure();
    test_mid_reset();
    test_snapshot();
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/df_sign_fir.md
# df_sign_fir

Sequential multi-tap FIR stage for the digital filter macro, directly downstream of `df_opt_2comp`. Coefficients are restricted to ±2^s or zero. The block keeps a delay line of unsigned 8-bit samples and walks it one tap per cycle. Each tap is fed through one `df_opt_2comp` instance, with `en` driven by the tap's sign bit, to get a 9-bit signed term. The term is shifted and accumulated into a wide signed sum, and the result is offered on a ready/valid output.

## Interface
- `NTAPS`, default 4: number of taps, ≥2.
- `ACC_W`, default 16: accumulator/output width. Must be ≥ 12 + clog2(NTAPS); no overflow handling.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 8: unsigned input sample.
- `in_valid` in 1: sample offered.
- `in_ready` out 1: block accepts a sample; high only in IDLE.
- `coef_en` in NTAPS: per-tap enable. 0 means the tap contributes 0.
- `coef_neg` in NTAPS: per-tap sign, 1 = negative. Drives `df_opt_2comp.en`.
- `coef_shift` in 2·NTAPS: per-tap left shift 0..3. Tap k uses bits [2k+1:2k].
- `out_data` out ACC_W: signed two's-complement filter result.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.

## Operation
- Weight of tap k is w_k = coef_en[k] · (coef_neg[k] ? −1 : +1) · 2^coef_shift[k].
- Output is y[n] = Σ_{k=0}^{NTAPS−1} w_k · x[n−k]. Tap 0 holds the newest sample.
- Delay line is NTAPS × 8-bit registers, all cleared by reset. Unfilled taps contribute 0.
- The FSM has three states: IDLE, ACCUM, OUTPUT.
- **IDLE**:
  - `in_ready`=1.
  - On `in_valid` && `in_ready`: shift the delay line (x→tap0, tap k→tap k+1, oldest dropped).
  - On the same edge, snapshot `coef_en`/`coef_neg`/`coef_shift` into internal registers, set acc=0 and tap_idx=0, and go to ACCUM.
- **ACCUM**: each cycle, for tap k = tap_idx:
  - Compute the term from the delay-line value and the coefficient snapshot (see term rules).
  - acc += term, then tap_idx++.
  - On the edge that adds tap NTAPS−1: load `out_data` with the final sum, set `out_valid`=1, and go to OUTPUT.
- **OUTPUT**:
  - Hold `out_data` and `out_valid`.
  - On the edge with `out_valid` && `out_ready`: clear `out_valid` and go to IDLE.
- Term rules:
  - The `df_opt_2comp` output is a 9-bit signed value in −255..+255.
  - Sign-extend it to ACC_W, then shift left by the snapshot shift.
  - If the snapshot enable is 0, the term is 0.
- Acc arithmetic is ACC_W-bit two's complement. With ACC_W at its minimum, no wrap is possible.
- Coefficient inputs changing outside the accept edge have no effect on a result in progress.
- `in_valid` outside IDLE is ignored; the sample stays unaccepted until the next IDLE.
- Reset (asynchronous, any state):
  - State → IDLE, acc=0, tap_idx=0.
  - Delay line and coefficient snapshot are cleared.
  - `out_data`=0, `out_valid`=0, `in_ready`=1 (IDLE).
  - A result in progress is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0.
- Accept edge E0. Terms are added on edges E1..E_NTAPS.
- `out_valid` rises after E_NTAPS: latency is NTAPS cycles from accept to valid.
- With `out_ready` held high, OUTPUT lasts 1 cycle. IDLE follows, and the next accept is at E_{NTAPS+2}.
- Minimum sample period is NTAPS+2 cycles; 6 for the default.
- `out_data` is registered and stable throughout OUTPUT.
- `in_ready` is a pure function of state, with no combinational path from `in_valid` or `out_ready`.

## Test plan
Default NTAPS=4, ACC_W=16.
- All taps enabled, +1, shift 0; feed 10, 20, 30, 40 → outputs 10, 30, 60, 100. Each result arrives 4 cycles after its accept, and samples are accepted every 6 cycles.
- Tap0 +1, tap1 −1, taps 2–3 disabled; feed 200, 50 → outputs 200, −150 (0xFF6A).
- All taps enabled, −1, shift 3; feed 255 ×4 → outputs −2040, −4080, −6120, −8160 (0xE020).
- Backpressure: `out_ready`=0 for 5 cycles in OUTPUT while `in_valid`=1 with `in_data`=99.
  - Required: `out_data` stable, `in_ready`=0, and 99 not accepted.
  - Then raise `out_ready`: IDLE follows, and 99 is accepted on the next cycle.
- Assert `rst_n` low for 1 cycle mid-ACCUM after feeding 100, 100. Required:
  - `out_valid`=0 immediately and no result for that sample.
  - Next, feed 7 with all +1 → output 7, because the delay line was cleared.
- Accept 40 with all +1, then flip every `coef_neg` to 1 during ACCUM → result uses the snapshot, i.e. +40 on an empty line.
